// File: rtl/vga_clock_pkg.sv
// Shared types and constants for the pixel-clock MMCM runtime sequencer.
// Holds DRP table entry layout, mode codes and FSM states.
package vga_clock_pkg;

    localparam int NUM_MODES = 4;

    localparam logic [2:0] VIC_1 = 3'd1;
    localparam logic [2:0] VIC_2 = 3'd2;
    localparam logic [2:0] VIC_3 = 3'd3;
    localparam logic [2:0] VIC_4 = 3'd4;

    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] mask;
        logic [15:0] data;
    } drp_entry_t;

    typedef enum logic [3:0] {
        IDLE,
        ASSERT_RST,
        RD,
        RD_WAIT,
        WR,
        WR_WAIT,
        NEXT,
        RELEASE,
        LOCK_WAIT,
        FAIL,
        VFY,
        VFY_WAIT
    } state_t;

    // Counter register 1: high time in [11:6], low time in [5:0].
    function automatic logic [15:0] div_hi_lo(input logic [6:0] d);
        logic [5:0] hi;
        logic [5:0] lo;
        hi = d[6:1];
        lo = 6'(d - {1'b0, d[6:1]});
        return {4'b0000, hi, lo};
    endfunction

    // Counter register 2: edge bit [7] set for odd divides.
    function automatic logic [15:0] div_edge(input logic [6:0] d);
        return {8'h00, d[0], 7'h00};
    endfunction

endpackage

// File: rtl/vga_clock_drp_rom.sv
// Per-mode MMCM DRP tables: (mode, index) -> address, keep-mask, data.
// Only CLKOUT0 and CLKFBOUT counters differ between video modes.
module vga_clock_drp_rom
    import vga_clock_pkg::*;
(
    input  logic [2:0] mode,
    input  logic [4:0] idx,
    output drp_entry_t entry
);

    logic [6:0] fb_mult;
    logic [6:0] out0_div;
    localparam logic [6:0] SPARE_DIV = 7'd10;

    // Table lookup: mode picks the mult/div pair, idx picks the register.
    always_comb begin
        fb_mult  = 7'd36;
        out0_div = 7'd8;
        unique case (mode)
            VIC_1:   begin fb_mult = 7'd30; out0_div = 7'd40; end
            VIC_2:   begin fb_mult = 7'd27; out0_div = 7'd33; end
            VIC_3:   begin fb_mult = 7'd27; out0_div = 7'd12; end
            default: begin fb_mult = 7'd36; out0_div = 7'd8;  end
        endcase
        entry = '{7'h00, 16'h0000, 16'h0000};
        unique case (idx)
            5'd0:  entry = '{7'h28, 16'h0000, 16'hFFFF};
            5'd1:  entry = '{7'h08, 16'h1000, div_hi_lo(out0_div)};
            5'd2:  entry = '{7'h09, 16'hFC00, div_edge(out0_div)};
            5'd3:  entry = '{7'h0A, 16'h1000, div_hi_lo(SPARE_DIV)};
            5'd4:  entry = '{7'h0B, 16'hFC00, div_edge(SPARE_DIV)};
            5'd5:  entry = '{7'h0C, 16'h1000, div_hi_lo(SPARE_DIV)};
            5'd6:  entry = '{7'h0D, 16'hFC00, div_edge(SPARE_DIV)};
            5'd7:  entry = '{7'h0E, 16'h1000, div_hi_lo(SPARE_DIV)};
            5'd8:  entry = '{7'h0F, 16'hFC00, div_edge(SPARE_DIV)};
            5'd9:  entry = '{7'h10, 16'h1000, div_hi_lo(SPARE_DIV)};
            5'd10: entry = '{7'h11, 16'hFC00, div_edge(SPARE_DIV)};
            5'd11: entry = '{7'h06, 16'h1000, div_hi_lo(SPARE_DIV)};
            5'd12: entry = '{7'h07, 16'hFC00, div_edge(SPARE_DIV)};
            5'd13: entry = '{7'h12, 16'h1000, div_hi_lo(SPARE_DIV)};
            5'd14: entry = '{7'h13, 16'hFC00, div_edge(SPARE_DIV)};
            5'd15: entry = '{7'h16, 16'hC000, 16'h1041};
            5'd16: entry = '{7'h14, 16'h1000, div_hi_lo(fb_mult)};
            5'd17: entry = '{7'h15, 16'hFC00, div_edge(fb_mult)};
            5'd18: entry = '{7'h18, 16'hFC00, 16'h03E8};
            5'd19: entry = '{7'h19, 16'h8000, 16'h7C01};
            5'd20: entry = '{7'h1A, 16'h8000, 16'h7FE9};
            5'd21: entry = '{7'h4E, 16'h66FF, 16'h0900};
            5'd22: entry = '{7'h4F, 16'h666F, 16'h1000};
            default: entry = '{7'h00, 16'h0000, 16'h0000};
        endcase
    end

endmodule

// File: rtl/vga_clock_reconfig.sv
// Runtime video-mode sequencer: reprograms the pixel-clock MMCM over DRP.
// Optional readback check of every write: VGA_CLOCK_RECONFIG_VERIFY_EN.
module vga_clock_reconfig #(
    parameter int NUM_REGS     = 23,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int DEFAULT_MODE = 4
) (
    input  logic        clk_33,
    input  logic        reset,
    input  logic [2:0]  mode_code,
    input  logic        mode_valid,
    output logic        mode_ready,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [6:0]  drp_daddr,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic        mmcm_rst,
    input  logic        mmcm_locked,
    output logic [2:0]  current_mode,
    output logic        busy,
    output logic        pixel_clk_good,
    output logic        error,
    output logic        done
);
    import vga_clock_pkg::*;

    localparam int CW = $clog2(LOCK_TIMEOUT + 1);

    state_t      state;
    state_t      state_n;
    logic [4:0]  idx;
    logic [2:0]  target;
    logic [15:0] wdata;
    logic [CW-1:0] cnt;
    drp_entry_t  ent;
    logic        code_ok;
    logic        new_req;
    logic        drdy_hit;
    logic        lock_hit;
    logic        last;

    vga_clock_drp_rom u_rom (
        .mode  (target),
        .idx   (idx),
        .entry (ent)
    );

    assign code_ok  = (mode_code != 3'd0) && (mode_code <= 3'(NUM_MODES));
    assign new_req  = code_ok && !((mode_code == current_mode) && !error);
    assign drdy_hit = (cnt == CW'(DRDY_TIMEOUT - 1));
    assign lock_hit = (cnt == CW'(LOCK_TIMEOUT - 1));
    assign last     = (idx == 5'(NUM_REGS - 1));

    assign mode_ready     = (state == IDLE);
    assign busy           = (state != IDLE);
    assign pixel_clk_good = mmcm_locked && (state == IDLE) && !error;

    // State register; reset restarts a full program of the default mode.
    always_ff @(posedge clk_33 or posedge reset) begin
        if (reset) state <= ASSERT_RST;
        else       state <= state_n;
    end

    // Next-state and DRP strobes.
    always_comb begin
        state_n   = state;
        drp_den   = 1'b0;
        drp_dwe   = 1'b0;
        drp_daddr = 7'h00;
        drp_di    = 16'h0000;
        unique case (state)
            IDLE: begin
                if (mode_valid && new_req) state_n = ASSERT_RST;
            end
            ASSERT_RST: state_n = RD;
            RD: begin
                drp_den   = 1'b1;
                drp_daddr = ent.addr;
                state_n   = RD_WAIT;
            end
            RD_WAIT: begin
                if (drp_drdy)      state_n = WR;
                else if (drdy_hit) state_n = FAIL;
            end
            WR: begin
                drp_den   = 1'b1;
                drp_dwe   = 1'b1;
                drp_daddr = ent.addr;
                drp_di    = wdata;
                state_n   = WR_WAIT;
            end
            WR_WAIT: begin
`ifdef VGA_CLOCK_RECONFIG_VERIFY_EN
                if (drp_drdy)      state_n = VFY;
`else
                if (drp_drdy)      state_n = NEXT;
`endif
                else if (drdy_hit) state_n = FAIL;
            end
`ifdef VGA_CLOCK_RECONFIG_VERIFY_EN
            VFY: begin
                drp_den   = 1'b1;
                drp_daddr = ent.addr;
                state_n   = VFY_WAIT;
            end
            VFY_WAIT: begin
                if (drp_drdy) begin
                    if (((drp_do ^ wdata) & ~ent.mask) != 16'h0000)
                        state_n = FAIL;
                    else
                        state_n = NEXT;
                end else if (drdy_hit) begin
                    state_n = FAIL;
                end
            end
`endif
            NEXT:      state_n = last ? RELEASE : RD;
            RELEASE:   state_n = LOCK_WAIT;
            LOCK_WAIT: begin
                if (mmcm_locked)   state_n = IDLE;
                else if (lock_hit) state_n = FAIL;
            end
            FAIL:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // Datapath: request latch, table index, merge value, timeouts, status.
    always_ff @(posedge clk_33 or posedge reset) begin
        if (reset) begin
            idx          <= 5'd0;
            target       <= 3'(DEFAULT_MODE);
            wdata        <= 16'h0000;
            cnt          <= '0;
            current_mode <= 3'(DEFAULT_MODE);
            error        <= 1'b0;
            done         <= 1'b0;
            mmcm_rst     <= 1'b1;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mode_valid) begin
                        if (!code_ok) begin
                            error <= 1'b1;
                            done  <= 1'b1;
                        end else if (!new_req) begin
                            done  <= 1'b1;
                        end else begin
                            error  <= 1'b0;
                            target <= mode_code;
                            idx    <= 5'd0;
                        end
                    end
                end
                ASSERT_RST: mmcm_rst <= 1'b1;
                RD, WR, VFY: cnt <= '0;
                RD_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (drp_drdy) wdata <= (drp_do & ent.mask) | ent.data;
                end
                WR_WAIT, VFY_WAIT: cnt <= cnt + 1'b1;
                NEXT: begin
                    if (!last) idx <= idx + 5'd1;
                end
                RELEASE: begin
                    mmcm_rst <= 1'b0;
                    cnt      <= '0;
                end
                LOCK_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (mmcm_locked) begin
                        current_mode <= target;
                        done         <= 1'b1;
                    end
                end
                FAIL: begin
                    error    <= 1'b1;
                    done     <= 1'b1;
                    mmcm_rst <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_clock_reconfig.sv
// Scoreboard bench for vga_clock_reconfig with a DRP/MMCM behavioural model.
// Expected writes are queued at read-ack time; done outcomes are queued per request.
module tb_vga_clock_reconfig;

    localparam int DRDY_TO = 64;
    localparam int LOCK_TO = 65536;

    logic        clk_33 = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  mode_code = 3'd0;
    logic        mode_valid = 1'b0;
    logic        mode_ready;
    logic        drp_den;
    logic        drp_dwe;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di;
    logic [15:0] drp_do = 16'h0000;
    logic        drp_drdy = 1'b0;
    logic        mmcm_rst;
    logic        mmcm_locked = 1'b0;
    logic [2:0]  current_mode;
    logic        busy;
    logic        pixel_clk_good;
    logic        error;
    logic        done;

    vga_clock_reconfig dut (
        .clk_33         (clk_33),
        .reset          (reset),
        .mode_code      (mode_code),
        .mode_valid     (mode_valid),
        .mode_ready     (mode_ready),
        .drp_den        (drp_den),
        .drp_dwe        (drp_dwe),
        .drp_daddr      (drp_daddr),
        .drp_di         (drp_di),
        .drp_do         (drp_do),
        .drp_drdy       (drp_drdy),
        .mmcm_rst       (mmcm_rst),
        .mmcm_locked    (mmcm_locked),
        .current_mode   (current_mode),
        .busy           (busy),
        .pixel_clk_good (pixel_clk_good),
        .error          (error),
        .done           (done)
    );

    initial forever #5 clk_33 = ~clk_33;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    initial forever begin
        @(posedge clk_33);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Hand-written DRP tables (addresses, keep-masks, mode-independent data).
    logic [6:0] tbl_addr [23] = '{
        7'h28, 7'h08, 7'h09, 7'h0A, 7'h0B, 7'h0C, 7'h0D, 7'h0E,
        7'h0F, 7'h10, 7'h11, 7'h06, 7'h07, 7'h12, 7'h13, 7'h16,
        7'h14, 7'h15, 7'h18, 7'h19, 7'h1A, 7'h4E, 7'h4F};
    logic [15:0] tbl_mask [23] = '{
        16'h0000, 16'h1000, 16'hFC00, 16'h1000, 16'hFC00, 16'h1000,
        16'hFC00, 16'h1000, 16'hFC00, 16'h1000, 16'hFC00, 16'h1000,
        16'hFC00, 16'h1000, 16'hFC00, 16'hC000, 16'h1000, 16'hFC00,
        16'hFC00, 16'h8000, 16'h8000, 16'h66FF, 16'h666F};
    logic [15:0] tbl_data [23] = '{
        16'hFFFF, 16'h0000, 16'h0000, 16'h0145, 16'h0000, 16'h0145,
        16'h0000, 16'h0145, 16'h0000, 16'h0145, 16'h0000, 16'h0145,
        16'h0000, 16'h0145, 16'h0000, 16'h1041, 16'h0000, 16'h0000,
        16'h03E8, 16'h7C01, 16'h7FE9, 16'h0900, 16'h1000};

    // Mode-specific words: out0 div 40/33/8, feedback mult 30/27/36.
    function automatic logic [15:0] exp_data(input int m, input int i);
        logic [15:0] d;
        d = tbl_data[i];
        case (i)
            1:  d = (m == 1) ? 16'h0514 : (m == 2) ? 16'h0411 : 16'h0104;
            2:  d = (m == 2) ? 16'h0080 : 16'h0000;
            16: d = (m == 1) ? 16'h03CF : (m == 2) ? 16'h034E : 16'h0492;
            17: d = (m == 2) ? 16'h0080 : 16'h0000;
            default: ;
        endcase
        return d;
    endfunction

    function automatic logic [15:0] rdpat(input logic [6:0] a);
        return 16'hA5C3 ^ {a, a, 2'b01};
    endfunction

    typedef struct {
        logic [6:0]  a;
        logic [15:0] d;
    } wexp_t;

    wexp_t       wq [$];
    logic [3:0]  dq [$];

    int exp_mode = 4;
    int exp_i = 0;
    int den_cnt = 0;
    int last_den_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int rst_fall_cyc = 0;
    bit ack_en = 1;
    bit lock_en = 1;
`ifdef VGA_CLOCK_RECONFIG_VERIFY_EN
    bit corrupt = 0;
`endif

    // DRP model: ack 3 cycles after den; read acks queue the expected write.
    initial begin
        int    pend;
        bit    ppush;
        wexp_t pexp;
        logic [15:0] pdo;
        logic [6:0]  lwa;
        logic [15:0] lwd;
        bit    was_w;
        bit    is_vfy;
        pend = 0; ppush = 0; pdo = 0; lwa = 0; lwd = 0; was_w = 0;
        pexp = '{7'h00, 16'h0000};
        forever begin
            @(negedge clk_33);
            drp_drdy = 1'b0;
            if (reset) begin
                pend = 0;
                was_w = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        drp_drdy = 1'b1;
                        drp_do = pdo;
                        if (ppush) wq.push_back(pexp);
                    end
                end
                if (drp_den) begin
                    den_cnt++;
                    last_den_cyc = cyc;
                    ppush = 0;
                    pdo = 16'h0000;
                    if (drp_dwe) begin
                        lwa = drp_daddr;
                        lwd = drp_di;
                        was_w = 1;
                    end else begin
                        is_vfy = 0;
`ifdef VGA_CLOCK_RECONFIG_VERIFY_EN
                        is_vfy = was_w && (drp_daddr == lwa);
`endif
                        was_w = 0;
                        if (is_vfy) begin
                            pdo = lwd;
`ifdef VGA_CLOCK_RECONFIG_VERIFY_EN
                            if (corrupt) pdo = lwd ^ 16'h0001;
`endif
                        end else if (exp_i < 23) begin
                            chk("rd_addr", 32'(drp_daddr), 32'(tbl_addr[exp_i]));
                            pdo = rdpat(drp_daddr);
                            pexp.a = tbl_addr[exp_i];
                            pexp.d = (pdo & tbl_mask[exp_i]) | exp_data(exp_mode, exp_i);
                            ppush = 1;
                            exp_i++;
                        end else begin
                            chk("rd_extra", 32'(exp_i), 32'd22);
                        end
                    end
                    if (ack_en) pend = 3;
                end
            end
        end
    end

    // MMCM lock model: lock 100 cycles after mmcm_rst falls.
    initial begin
        int lcnt;
        logic prev;
        lcnt = 0;
        prev = 1'b1;
        forever begin
            @(negedge clk_33);
            if (prev && !mmcm_rst) rst_fall_cyc = cyc;
            prev = mmcm_rst;
            if (mmcm_rst) begin
                lcnt = 0;
                mmcm_locked = 1'b0;
            end else if (lock_en) begin
                lcnt++;
                if (lcnt >= 100) mmcm_locked = 1'b1;
            end
        end
    end

    // Monitor: compare DRP writes and done outcomes against the queues.
    initial forever begin
        wexp_t w;
        logic [3:0] d;
        @(negedge clk_33);
        if (!reset && drp_den && drp_dwe) begin
            if (wq.size() == 0) begin
                chk("wr_unexpected", 32'(drp_daddr), 32'h7F);
            end else begin
                w = wq.pop_front();
                chk("wr_addr", 32'(drp_daddr), 32'(w.a));
                chk("wr_data", 32'(drp_di), 32'(w.d));
                chk("wr_mmcm_rst", 32'(mmcm_rst), 32'd1);
            end
        end
        if (!reset && done) begin
            done_cnt++;
            done_cyc = cyc;
            if (dq.size() == 0) begin
                chk("done_unexpected", 32'(done), 32'd0);
            end else begin
                d = dq.pop_front();
                chk("done_mode", 32'(current_mode), 32'(d[2:0]));
                chk("done_error", 32'(error), 32'(d[3]));
            end
        end
    end

    task automatic req(input logic [2:0] c);
        @(negedge clk_33);
        chk("mode_ready", 32'(mode_ready), 32'd1);
        mode_code = c;
        mode_valid = 1'b1;
        @(negedge clk_33);
        mode_valid = 1'b0;
    endtask

    task automatic wait_done(input int start, input int budget);
        int n;
        n = 0;
        while (done_cnt == start && n < budget) begin
            @(negedge clk_33);
            n++;
        end
        chk("done_timeout", 32'(done_cnt != start), 32'd1);
        @(negedge clk_33);
    endtask

    initial begin
        int s;
        int dc;
        int n;
        repeat (3) @(negedge clk_33);
        chk("rst_den", {drp_den, drp_dwe}, 32'd0);
        chk("rst_addr_di", {drp_daddr, drp_di}, 32'd0);
        chk("rst_mmcm", 32'(mmcm_rst), 32'd1);
        chk("rst_mode", 32'(current_mode), 32'd4);
        chk("rst_busy_rdy", {busy, mode_ready}, 32'b10);
        chk("rst_err_done", {error, done}, 32'd0);

        // Auto-program of the default mode.
        exp_mode = 4; exp_i = 0; dq.push_back(4'h4);
        s = done_cnt;
        reset = 1'b0;
        wait_done(s, 3000);
        chk("p4_regs", 32'(exp_i), 32'd23);
        chk("p4_status", {busy, pixel_clk_good, mode_ready}, 32'b011);

        // Mode 2.
        exp_mode = 2; exp_i = 0; dq.push_back(4'h2);
        s = done_cnt;
        req(3'd2);
        wait_done(s, 3000);
        chk("p2_regs", 32'(exp_i), 32'd23);
        chk("p2_status", {busy, pixel_clk_good, current_mode}, {2'b01, 3'd2});

        // Invalid code: error, no DRP or reset activity.
        dc = den_cnt; dq.push_back(4'hA);
        s = done_cnt;
        req(3'd7);
        wait_done(s, 20);
        chk("bad_no_den", 32'(den_cnt), 32'(dc));
        chk("bad_flags", {error, mmcm_rst, pixel_clk_good}, 32'b100);

        // Mode 1 clears the error.
        exp_mode = 1; exp_i = 0; dq.push_back(4'h1);
        s = done_cnt;
        req(3'd1);
        wait_done(s, 3000);
        chk("p1_status", {error, pixel_clk_good, current_mode}, {2'b01, 3'd1});

        // Same mode again: immediate done, nothing reprogrammed.
        dc = den_cnt; dq.push_back(4'h1);
        s = done_cnt;
        req(3'd1);
        wait_done(s, 20);
        chk("same_no_den", 32'(den_cnt), 32'(dc));

        // DRP never acks.
        ack_en = 0; exp_mode = 3; exp_i = 0; dq.push_back(4'h9);
        s = done_cnt;
        req(3'd3);
        wait_done(s, 500);
        chk("drdy_to_cycles", 32'(done_cyc - last_den_cyc), 32'(DRDY_TO + 2));
        chk("drdy_to_flags", {error, mmcm_rst, current_mode}, {2'b11, 3'd1});
        ack_en = 1;

        // Lock never arrives.
        lock_en = 0; exp_mode = 2; exp_i = 0; dq.push_back(4'h9);
        s = done_cnt;
        req(3'd2);
        wait_done(s, 70000);
        chk("lock_to_cycles", 32'(done_cyc - rst_fall_cyc), 32'(LOCK_TO + 1));
        chk("lock_to_flags", {error, mmcm_rst, current_mode}, {2'b11, 3'd1});
        lock_en = 1;

        // Reset in the middle of the table.
        exp_mode = 2; exp_i = 0;
        req(3'd2);
        n = 0;
        while (exp_i < 11 && n < 1000) begin
            @(negedge clk_33);
            n++;
        end
        chk("mid_reached", 32'(exp_i), 32'd11);
        reset = 1'b1;
        #1;
        chk("mid_rst_drp", {drp_den, drp_dwe, drp_daddr, drp_di}, 32'd0);
        chk("mid_rst_flags", {mmcm_rst, busy, mode_ready, error, done}, 32'b11000);
        chk("mid_rst_mode", 32'(current_mode), 32'd4);
        wq.delete();
        @(negedge clk_33);
        exp_mode = 4; exp_i = 0; dq.push_back(4'h4);
        s = done_cnt;
        reset = 1'b0;
        wait_done(s, 3000);
        chk("re4_regs", 32'(exp_i), 32'd23);
        chk("re4_status", {busy, pixel_clk_good, current_mode}, {2'b01, 3'd4});

`ifdef VGA_CLOCK_RECONFIG_VERIFY_EN
        // Corrupted readback on a compared bit.
        corrupt = 1; exp_mode = 2; exp_i = 0; dq.push_back(4'hC);
        s = done_cnt;
        req(3'd2);
        wait_done(s, 500);
        chk("vfy_error", {error, mmcm_rst}, 32'b11);
        corrupt = 0;
`endif

        chk("sb_wq_empty", 32'(wq.size()), 32'd0);
        chk("sb_dq_empty", 32'(dq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
